// File: rtl/id_stage_pkg.sv
// Shared ARM decode encodings: instruction modes, data-processing opcodes,
// ALU commands, condition codes and NZCV flag positions.
package id_stage_pkg;

    typedef enum logic [1:0] {
        MODE_DP  = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_TST = 4'b1000;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;

    typedef enum logic [3:0] {
        EXE_NOP = 4'b0000,
        EXE_MOV = 4'b0001,
        EXE_ADD = 4'b0010,
        EXE_ADC = 4'b0011,
        EXE_SUB = 4'b0100,
        EXE_SBC = 4'b0101,
        EXE_AND = 4'b0110,
        EXE_ORR = 4'b0111,
        EXE_EOR = 4'b1000,
        EXE_MVN = 4'b1001
    } exe_cmd_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Index 15 is the PC: never stored in the file, read back as pc_in.
    localparam logic [3:0] PC_IDX = 4'hF;

endpackage

// File: rtl/id_stage_register_file.sv
// Architectural register file R0-R14 with one write port and two
// combinational read ports that bypass the same-cycle WB write.
module register_file
    import id_stage_pkg::*;
#(
    parameter int NUM_REGS = 15,
    parameter int WORD     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [3:0]      wr_idx,
    input  logic [WORD-1:0] wr_data,
    input  logic [WORD-1:0] pc_in,
    input  logic [3:0]      rd_idx_a,
    input  logic [3:0]      rd_idx_b,
    output logic [WORD-1:0] rd_data_a,
    output logic [WORD-1:0] rd_data_b
);

    logic [WORD-1:0] regs [NUM_REGS];
    logic            wr_live;

    assign wr_live = wr_en && (wr_idx != PC_IDX) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_idx] <= wr_data;
        end
    end

    function automatic logic [WORD-1:0] read_port(input logic [3:0] idx);
        if (rst)                             return '0;
        else if (idx == PC_IDX)              return pc_in;
        else if (wr_live && wr_idx == idx)   return wr_data;
        else                                 return regs[idx];
    endfunction

    assign rd_data_a = read_port(rd_idx_a);
    assign rd_data_b = read_port(rd_idx_b);

endmodule

// File: rtl/id_stage.sv
// ARM instruction-decode stage: control unit, condition check, source
// extraction for the hazard unit and the register file read/write.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int NUM_REGS = 15,
    parameter int WORD     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [WORD-1:0] pc_in,
    input  logic [31:0]     instruction,
    input  logic [3:0]      status,
    input  logic            hazard,
    input  logic            wb_wb_en,
    input  logic [3:0]      wb_dest,
    input  logic [WORD-1:0] wb_value,
    output logic [WORD-1:0] pc,
    output logic            wb_en,
    output logic            mem_r_en,
    output logic            mem_w_en,
    output logic            b,
    output logic            s,
    output logic [3:0]      exe_cmd,
    output logic [WORD-1:0] val_rn,
    output logic [WORD-1:0] val_rm,
    output logic            imm,
    output logic [11:0]     shift_operand,
    output logic [23:0]     signed_imm_24,
    output logic [3:0]      dest,
    output logic [3:0]      src1,
    output logic [3:0]      src2,
    output logic            two_src
);

    logic [3:0] cond, opcode, rn, rd, rm;
    logic [1:0] mode;
    logic       s_bit;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign rn     = instruction[19:16];
    assign rd     = instruction[15:12];
    assign rm     = instruction[3:0];

    exe_cmd_e exe_pre;
    logic     wb_pre, mr_pre, mw_pre, b_pre, s_pre;

    always_comb begin
        exe_pre = EXE_NOP;
        wb_pre  = 1'b0;
        mr_pre  = 1'b0;
        mw_pre  = 1'b0;
        b_pre   = 1'b0;
        s_pre   = 1'b0;
        case (mode_e'(mode))
            MODE_DP: begin
                s_pre  = s_bit;
                wb_pre = 1'b1;
                case (opcode)
                    OP_MOV:  exe_pre = EXE_MOV;
                    OP_MVN:  exe_pre = EXE_MVN;
                    OP_ADD:  exe_pre = EXE_ADD;
                    OP_ADC:  exe_pre = EXE_ADC;
                    OP_SUB:  exe_pre = EXE_SUB;
                    OP_SBC:  exe_pre = EXE_SBC;
                    OP_AND:  exe_pre = EXE_AND;
                    OP_ORR:  exe_pre = EXE_ORR;
                    OP_EOR:  exe_pre = EXE_EOR;
                    OP_CMP: begin
                        exe_pre = EXE_SUB;
                        wb_pre  = 1'b0;
                        s_pre   = 1'b1;
                    end
                    OP_TST: begin
                        exe_pre = EXE_AND;
                        wb_pre  = 1'b0;
                        s_pre   = 1'b1;
                    end
                    default: begin
                        wb_pre = 1'b0;
                        s_pre  = 1'b0;
                    end
                endcase
            end
            MODE_MEM: begin
                exe_pre = EXE_ADD;
                mr_pre  = s_bit;
                wb_pre  = s_bit;
                mw_pre  = !s_bit;
            end
            MODE_BR:  b_pre = 1'b1;
            default:  ;
        endcase
    end

    logic n_f, z_f, c_f, v_f, cond_ok;

    assign n_f = status[FLAG_N];
    assign z_f = status[FLAG_Z];
    assign c_f = status[FLAG_C];
    assign v_f = status[FLAG_V];

    always_comb begin
        case (cond_e'(cond))
            COND_EQ: cond_ok = z_f;
            COND_NE: cond_ok = !z_f;
            COND_CS: cond_ok = c_f;
            COND_CC: cond_ok = !c_f;
            COND_MI: cond_ok = n_f;
            COND_PL: cond_ok = !n_f;
            COND_VS: cond_ok = v_f;
            COND_VC: cond_ok = !v_f;
            COND_HI: cond_ok = c_f && !z_f;
            COND_LS: cond_ok = !c_f || z_f;
            COND_GE: cond_ok = (n_f == v_f);
            COND_LT: cond_ok = (n_f != v_f);
            COND_GT: cond_ok = !z_f && (n_f == v_f);
            COND_LE: cond_ok = z_f || (n_f != v_f);
            COND_AL: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    logic bubble;
    assign bubble = hazard || !cond_ok;

    assign wb_en    = wb_pre && !bubble;
    assign mem_r_en = mr_pre && !bubble;
    assign mem_w_en = mw_pre && !bubble;
    assign b        = b_pre  && !bubble;
    assign s        = s_pre  && !bubble;
    assign exe_cmd  = bubble ? 4'b0000 : exe_pre;

    // Store data lives in Rd, so the hazard unit must see Rd as the second source.
    assign src1    = rn;
    assign src2    = mw_pre ? rd : rm;
    assign two_src = !instruction[25] || mw_pre;

    assign pc            = pc_in;
    assign imm           = instruction[25];
    assign shift_operand = instruction[11:0];
    assign signed_imm_24 = instruction[23:0];
    assign dest          = rd;

    register_file #(
        .NUM_REGS (NUM_REGS),
        .WORD     (WORD)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wb_wb_en),
        .wr_idx    (wb_dest),
        .wr_data   (wb_value),
        .pc_in     (pc_in),
        .rd_idx_a  (src1),
        .rd_idx_b  (src2),
        .rd_data_a (val_rn),
        .rd_data_b (val_rm)
    );

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: driver pushes model expectations, monitor
// pops and compares on the falling edge.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, instruction, wb_value;
    logic [3:0]  status, wb_dest;
    logic        hazard, wb_wb_en;
    logic [31:0] pc, val_rn, val_rm;
    logic        wb_en, mem_r_en, mem_w_en, b, s, imm, two_src;
    logic [3:0]  exe_cmd, dest, src1, src2;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm_24;

    id_stage dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .instruction(instruction),
        .status(status), .hazard(hazard), .wb_wb_en(wb_wb_en),
        .wb_dest(wb_dest), .wb_value(wb_value), .pc(pc), .wb_en(wb_en),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .b(b), .s(s),
        .exe_cmd(exe_cmd), .val_rn(val_rn), .val_rm(val_rm), .imm(imm),
        .shift_operand(shift_operand), .signed_imm_24(signed_imm_24),
        .dest(dest), .src1(src1), .src2(src2), .two_src(two_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc_in;
        logic [31:0] instr;
        logic [3:0]  status;
        logic        hazard;
        logic        wb_we;
        logic [3:0]  wb_dest;
        logic [31:0] wb_value;
    } stim_t;

    typedef struct {
        int          id;
        logic [31:0] pc, val_rn, val_rm;
        logic        wb_en, mem_r_en, mem_w_en, b, s, imm, two_src;
        logic [3:0]  exe_cmd, dest, src1, src2;
        logic [11:0] shift_operand;
        logic [23:0] simm;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [15];
    stim_t       prev;
    int          checks = 0;
    int          errors = 0;
    int          vec_id = 0;

    function automatic bit cond_true(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cy = f[1], v = f[0];
        case (c)
            0: return z;        1: return !z;
            2: return cy;       3: return !cy;
            4: return n;        5: return !n;
            6: return v;        7: return !v;
            8: return cy && !z; 9: return !cy || z;
            10: return n == v;  11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input stim_t v, input logic [3:0] idx);
        if (v.rst) return 32'h0;
        if (idx == 4'd15) return v.pc_in;
        if (v.wb_we && v.wb_dest != 4'd15 && v.wb_dest == idx) return v.wb_value;
        return mregs[idx];
    endfunction

    function automatic exp_t model(input stim_t v);
        exp_t e;
        logic [3:0] op = v.instr[24:21];
        logic [3:0] exe = 4'd0;
        logic we = 0, mr = 0, mw = 0, br = 0, sf = 0;
        case (v.instr[27:26])
            2'b00: begin
                we = 1;
                sf = v.instr[20];
                case (op)
                    4'b1101: exe = 4'd1;
                    4'b1111: exe = 4'd9;
                    4'b0100: exe = 4'd2;
                    4'b0101: exe = 4'd3;
                    4'b0010: exe = 4'd4;
                    4'b0110: exe = 4'd5;
                    4'b0000: exe = 4'd6;
                    4'b1100: exe = 4'd7;
                    4'b0001: exe = 4'd8;
                    4'b1010: begin exe = 4'd4; we = 0; sf = 1; end
                    4'b1000: begin exe = 4'd6; we = 0; sf = 1; end
                    default: begin we = 0; sf = 0; end
                endcase
            end
            2'b01: begin
                exe = 4'd2;
                if (v.instr[20]) begin mr = 1; we = 1; end
                else mw = 1;
            end
            2'b10: br = 1;
            default: ;
        endcase
        e.id            = vec_id;
        e.src1          = v.instr[19:16];
        e.src2          = mw ? v.instr[15:12] : v.instr[3:0];
        e.two_src       = !v.instr[25] || mw;
        if (v.hazard || !cond_true(v.instr[31:28], v.status)) begin
            exe = 0; we = 0; mr = 0; mw = 0; br = 0; sf = 0;
        end
        e.exe_cmd       = exe;
        e.wb_en         = we;
        e.mem_r_en      = mr;
        e.mem_w_en      = mw;
        e.b             = br;
        e.s             = sf;
        e.pc            = v.pc_in;
        e.imm           = v.instr[25];
        e.shift_operand = v.instr[11:0];
        e.simm          = v.instr[23:0];
        e.dest          = v.instr[15:12];
        e.val_rn        = model_read(v, e.src1);
        e.val_rm        = model_read(v, e.src2);
        return e;
    endfunction

    task automatic drive(input stim_t v);
        @(posedge clk);
        #1;
        if (!prev.rst && prev.wb_we && prev.wb_dest != 4'd15)
            mregs[prev.wb_dest] = prev.wb_value;
        if (v.rst)
            for (int i = 0; i < 15; i++) mregs[i] = 32'h0;
        rst         = v.rst;
        pc_in       = v.pc_in;
        instruction = v.instr;
        status      = v.status;
        hazard      = v.hazard;
        wb_wb_en    = v.wb_we;
        wb_dest     = v.wb_dest;
        wb_value    = v.wb_value;
        vec_id++;
        sb.push_back(model(v));
        prev = v;
    endtask

    function automatic stim_t mk(input logic [31:0] instr, input logic [3:0] st = 4'h0,
                                 input logic hz = 0, input logic we = 0,
                                 input logic [3:0] wd = 0, input logic [31:0] wv = 0,
                                 input logic r = 0);
        stim_t v;
        v.rst = r; v.pc_in = 32'h0000_1000 + 32'(vec_id * 4); v.instr = instr;
        v.status = st; v.hazard = hz; v.wb_we = we; v.wb_dest = wd; v.wb_value = wv;
        return v;
    endfunction

    function automatic logic [31:0] dp(input logic [3:0] c, input logic i, input logic [3:0] op,
                                       input logic sb_, input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [11:0] op2);
        return {c, 2'b00, i, op, sb_, rn, rd, op2};
    endfunction

    function automatic logic [31:0] mem(input logic i, input logic l, input logic [3:0] rn,
                                        input logic [3:0] rd, input logic [11:0] off);
        return {4'hE, 2'b01, i, 4'b1100, l, rn, rd, off};
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %h, want %h", name, id, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc",        e.id, pc,                    e.pc);
                chk("wb_en",     e.id, 32'(wb_en),            32'(e.wb_en));
                chk("mem_r_en",  e.id, 32'(mem_r_en),         32'(e.mem_r_en));
                chk("mem_w_en",  e.id, 32'(mem_w_en),         32'(e.mem_w_en));
                chk("b",         e.id, 32'(b),                32'(e.b));
                chk("s",         e.id, 32'(s),                32'(e.s));
                chk("exe_cmd",   e.id, 32'(exe_cmd),          32'(e.exe_cmd));
                chk("val_rn",    e.id, val_rn,                e.val_rn);
                chk("val_rm",    e.id, val_rm,                e.val_rm);
                chk("imm",       e.id, 32'(imm),              32'(e.imm));
                chk("shift_op",  e.id, 32'(shift_operand),    32'(e.shift_operand));
                chk("simm24",    e.id, 32'(signed_imm_24),    32'(e.simm));
                chk("dest",      e.id, 32'(dest),             32'(e.dest));
                chk("src1",      e.id, 32'(src1),             32'(e.src1));
                chk("src2",      e.id, 32'(src2),             32'(e.src2));
                chk("two_src",   e.id, 32'(two_src),          32'(e.two_src));
            end
        end
    end

    initial begin : driver
        stim_t v;
        logic [31:0] add_r1 = dp(4'hE, 1'b0, 4'b0100, 1'b1, 4'd2, 4'd1, 12'd3);
        logic [31:0] addeq  = dp(4'h0, 1'b0, 4'b0100, 1'b0, 4'd2, 4'd1, 12'd3);
        int drain;

        rst = 1; pc_in = 0; instruction = 0; status = 0; hazard = 0;
        wb_wb_en = 0; wb_dest = 0; wb_value = 0;
        prev = mk(32'h0, .r(1));
        for (int i = 0; i < 15; i++) mregs[i] = 32'h0;

        drive(mk(dp(4'hE, 0, 4'b1101, 0, 4'd5, 4'd0, 12'd6), .r(1)));
        drive(mk(dp(4'hE, 0, 4'b1101, 0, 4'd5, 4'd0, 12'd6), .we(1), .wd(4'd5), .wv(32'hDEADBEEF)));
        drive(mk(dp(4'hE, 0, 4'b1101, 0, 4'd5, 4'd0, 12'd5)));
        drive(mk(dp(4'hE, 0, 4'b1101, 0, 4'd5, 4'd0, 12'd5), .r(1)));
        for (int i = 0; i < 15; i += 2)
            drive(mk(dp(4'hE, 0, 4'b0100, 0, 4'(i), 4'd0, 12'(i + 1))));
        drive(mk(dp(4'hE, 0, 4'b0100, 0, 4'd3, 4'd1, 12'd3), .we(1), .wd(4'd3), .wv(32'h12345678)));
        drive(mk(dp(4'hE, 0, 4'b0100, 0, 4'd3, 4'd1, 12'd3)));
        drive(mk(add_r1));
        drive(mk(addeq, 4'b0000));
        drive(mk(addeq, 4'b0100, 1'b1));
        drive(mk(addeq, 4'b0100));
        drive(mk(mem(1'b0, 1'b0, 4'd2, 4'd4, 12'd8)));
        drive(mk(mem(1'b1, 1'b1, 4'd2, 4'd4, 12'd8)));
        drive(mk(dp(4'hE, 0, 4'b1010, 0, 4'd3, 4'd0, 12'd2)));
        drive(mk(dp(4'hE, 0, 4'b1000, 0, 4'd3, 4'd0, 12'd2)));
        drive(mk({4'hE, 3'b101, 1'b0, 24'h800010}));
        drive(mk({4'hF, 3'b101, 1'b0, 24'h000010}));
        drive(mk(dp(4'hE, 0, 4'b0100, 0, 4'd15, 4'd0, 12'd3), .we(1), .wd(4'd15), .wv(32'hCAFEF00D)));
        for (int i = 0; i < 15; i += 2)
            drive(mk(dp(4'hE, 0, 4'b0100, 0, 4'(i), 4'd0, 12'(i + 1))));

        for (int n = 0; n < 400; n++) begin
            v.rst      = ($urandom_range(0, 63) == 0);
            v.pc_in    = $urandom;
            v.instr    = $urandom;
            if ($urandom_range(0, 1) == 1) v.instr[31:28] = 4'hE;
            v.status   = 4'($urandom);
            v.hazard   = ($urandom_range(0, 7) == 0);
            v.wb_we    = 1'($urandom);
            v.wb_dest  = ($urandom_range(0, 3) == 0) ? v.instr[19:16] : 4'($urandom);
            v.wb_value = $urandom;
            drive(v);
        end

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        chk("scoreboard_drain", vec_id, 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
